// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word request at a time to instruction memory,
// buffers responses in a small circular FIFO and presents them downstream with a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
// Optional build macro OPCODE_FILTER_EN adds illegal_o, an opcode legality flag
// computed at push and stored alongside each FIFO entry.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
`ifdef OPCODE_FILTER_EN
  ,
  output logic        illegal_o
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIssue, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  // Held low during reset and for the first cycle after release, so a stale
  // response from before reset can never be mistaken for a fresh one.
  logic            armed_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     pc_last_q;
  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [31:0]     pc_mem    [FIFO_DEPTH];
  logic            push, pop, can_issue;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  // Only one request may be in flight; issuing from StIssue means none is, so the
  // current fill level alone decides whether the response has a slot waiting.
  assign can_issue     = armed_q && (count_q < Depth);
  assign imem_addr     = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_q] : Nop;
  assign pc_o          = instr_valid_o ? pc_mem[rd_ptr_q] : pc_last_q;

  // Fetch FSM next state, request strobe and push decision
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIssue: begin
        if (!redirect_i && can_issue) begin
          imem_req   = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          push    = !redirect_i;
          state_d = StIssue;
        end else if (redirect_i) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_rvalid) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    end
  end

  // FSM state, fetch PC and arming flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIssue;
      fetch_pc_q <= RESET_PC;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      armed_q    <= 1'b1;
    end
  end

  // FIFO pointers and fill count; a redirect empties the buffer outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Remember the head PC so pc_o holds its last value once the FIFO drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_last_q <= RESET_PC;
    end else if (instr_valid_o) begin
      pc_last_q <= pc_mem[rd_ptr_q];
    end
  end

  // Entry storage; the PC of the word in flight is one step behind fetch_pc
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q - 32'd4;
    end
  end

`ifdef OPCODE_FILTER_EN
  logic ill_mem [FIFO_DEPTH];
  logic rdata_illegal;

  // Classify the incoming opcode against the supported set
  always_comb begin
    rdata_illegal = 1'b1;
    case (imem_rdata[6:0])
      7'b0110011, 7'b0010011, 7'b0100011,
      7'b1100011, 7'b0110111, 7'b1101111: rdata_illegal = 1'b0;
      default:                            rdata_illegal = 1'b1;
    endcase
  end

  // Per-entry legality flag, written alongside the instruction
  always_ff @(posedge clk) begin
    if (push) begin
      ill_mem[wr_ptr_q] <= rdata_illegal;
    end
  end

  assign illegal_o = instr_valid_o && ill_mem[rd_ptr_q];
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit. Drives the `instr_i` input of the decode/register-file stage with one 32-bit instruction and its PC at a time.
- Issues word requests to instruction memory and buffers responses in a small FIFO.
- Presents instructions downstream with a valid/ready handshake.
- Flushes and restarts on a branch/jump redirect from execute.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_rvalid  in  1  response valid; arrives 1 or more cycles after imem_req.
- imem_rdata  in  32  response instruction word.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- instr_valid_o  out  1  FIFO head is valid.
- instr_o  out  32  FIFO head instruction; 32'h0000_0013 (NOP) when empty.
- pc_o  out  32  PC of FIFO head; last-held value when empty.
- instr_ready_i  in  1  downstream accepts head this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty, instr_valid_o=0, instr_o=NOP, pc_o=RESET_PC, state=ISSUE.
  - Reset mid-operation abandons any outstanding request; a response arriving after reset release while in ISSUE is ignored.
- FSM, at most one outstanding request:
  - ISSUE: if no redirect and (count + 0) < FIFO_DEPTH → imem_req=1, imem_addr=fetch_pc, fetch_pc+=4 (wraps modulo 2^32), go WAIT. Otherwise hold, imem_req=0.
  - WAIT: on imem_rvalid, push {fetch_pc-4, imem_rdata} into FIFO and go ISSUE. The next request may issue the cycle after the response (2-cycle minimum fetch period).
  - DROP: wait for imem_rvalid, discard the data, go ISSUE.
- Issue throttling: a request is only issued when a FIFO slot is free, counting the in-flight entry. A response is therefore never dropped for lack of space.
- Redirect (has priority over everything):
  - FIFO cleared the same edge, so instr_valid_o=0 the next cycle.
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}.
  - If in WAIT, go DROP. If in ISSUE, stay ISSUE with no request that cycle.
  - Redirect coinciding with imem_rvalid in WAIT: data discarded, go ISSUE (nothing left outstanding).
  - Redirect while in DROP: stay DROP, update fetch_pc.
  - Redirect coinciding with instr_ready_i: the pop is irrelevant, FIFO is cleared.
- FIFO:
  - Circular with wr/rd pointers and count.
  - Pop when instr_valid_o & instr_ready_i. Push and pop in the same cycle keep count unchanged.
  - Outputs come directly from the head entry (registered storage, no combinational path from imem_rdata).
  - instr_ready_i while empty has no effect.
- Latency: redirect at edge N → imem_req with the new PC at cycle N+1 (if no drop is pending). Response accepted at edge M → instr_valid_o=1 at cycle M+1.
- imem_req is never asserted in WAIT or DROP.

Optional Feature:
- Macro OPCODE_FILTER_EN.
- When defined:
  - Extra output port `illegal_o` (1 bit) = instr_valid_o & (instr_o[6:0] not in {0110011, 0010011, 0100011, 1100011, 0110111, 1101111}).
  - The opcode check is computed at push and stored per entry.
  - instr_o still carries the raw word.
- When undefined: port absent, no extra storage.

Test Plan:
- Reset with RESET_PC=32'h100, memory 1-cycle latency, ready=1:
  - Required: requests to 0x100, 0x104, 0x108 on alternate cycles.
  - Required: pc_o/instr_o sequence matches memory; instr_o=NOP before the first response.
- Backpressure, ready=0, FIFO_DEPTH=2:
  - Required: exactly 2 requests issued (0x0, 0x4), then imem_req stays 0.
  - Raising ready → pops 0x0, then the request for 0x8 issues.
- Redirect to 32'h0000_0203 while in WAIT, response arriving 3 cycles later with 0xDEADBEEF:
  - Required: that data is never presented.
  - Required: the next request is to 0x200, and pc_o=0x200 is the first valid output.
- Redirect coincident with imem_rvalid:
  - Required: data discarded, FIFO empty, next-cycle request to the redirect PC, no DROP state.
- Async reset asserted mid-WAIT, then a stale imem_rvalid after release:
  - Required: all outputs at reset values, stale data ignored, fetch restarts at RESET_PC.
- OPCODE_FILTER_EN:
  - Word 32'h0000_0073 → illegal_o=1 while at head.
  - Word 32'h0000_0033 → illegal_o=0.
